// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, one full-adder cell, LSB first, start/busy/done handshake
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [CW-1:0] cnt;
    logic carry, s, c_next, last;

    assign s      = op_a[0] ^ op_b[0] ^ carry;
    assign c_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign last   = cnt == CW'(WIDTH - 1);
    assign busy   = state == S_RUN;
    assign done   = state == S_FIN;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next-state: FIN lasts exactly one cycle so done is a single pulse
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_RUN : S_IDLE;
            S_RUN:   state_nx = last ? S_FIN : S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // datapath: operand capture, one bit per clock, results load only on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == S_IDLE && start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= c_next;
            res   <= {s, res[WIDTH-1:1]};
            cnt   <= last ? cnt : cnt + 1'b1;
            if (last) begin
                sum  <= {s, res[WIDTH-1:1]};
                cout <= c_next;
                ovf  <= carry ^ c_next;
            end
        end
    end
endmodule
